// File: rtl/bip_pkg.sv
// bip_pkg: shared definitions for the BIP control unit.
//   - default program-address / opcode widths
//   - opcode encodings, FSM state encoding
//   - accumulator input select and ALU op encodings
//   - ctl_t: decoded control bundle produced by bip_instr_decoder
package bip_pkg;

    localparam int DEF_PC_WIDTH     = 11;
    localparam int DEF_OPCODE_WIDTH = 5;

    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_HLT  = 5'b00000;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_STO  = 5'b00001;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_LD   = 5'b00010;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_LDI  = 5'b00011;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_ADD  = 5'b00100;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_ADDI = 5'b00101;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_SUB  = 5'b00110;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OPC_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_A_RAM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/bip_control_if.sv
// bip_control_if: bundle between the BIP control unit and its datapath/memories.
//   i_start       start pulse into the control unit
//   i_instr_data  program ROM read data (synchronous ROM)
//   o_instr_addr  program ROM address (PC)
//   o_operand     RAM address / immediate
//   o_rd_ram, o_wr_ram, o_sel_a, o_sel_b, o_op, o_wr_acc  datapath controls
//   o_halted, o_illegal, o_cycle_count                    status
// master: the control unit. slave: the datapath/memory side.
interface bip_control_if
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
);
    logic                             i_start;
    logic [OPCODE_WIDTH+PC_WIDTH-1:0] i_instr_data;
    logic [PC_WIDTH-1:0]              o_instr_addr;
    logic [PC_WIDTH-1:0]              o_operand;
    logic                             o_rd_ram;
    logic                             o_wr_ram;
    logic [1:0]                       o_sel_a;
    logic                             o_sel_b;
    logic                             o_op;
    logic                             o_wr_acc;
    logic                             o_halted;
    logic                             o_illegal;
    logic [31:0]                      o_cycle_count;

    modport master (
        input  i_start, i_instr_data,
        output o_instr_addr, o_operand, o_rd_ram, o_wr_ram, o_sel_a, o_sel_b,
               o_op, o_wr_acc, o_halted, o_illegal, o_cycle_count
    );

    modport slave (
        output i_start, i_instr_data,
        input  o_instr_addr, o_operand, o_rd_ram, o_wr_ram, o_sel_a, o_sel_b,
               o_op, o_wr_acc, o_halted, o_illegal, o_cycle_count
    );

endinterface

// File: rtl/bip_instr_decoder.sv
// bip_instr_decoder: purely combinational opcode -> control bundle.
//   opcode  in   OPCODE_WIDTH  instruction opcode field
//   ctl     out  ctl_t         sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, illegal
// Controls are unqualified here; the control unit gates them by FSM state.
module bip_instr_decoder
    import bip_pkg::*;
#(
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output ctl_t                    ctl
);

    always_comb begin
        ctl = '0;
        case (opcode)
            OPC_HLT: ctl = '0;  // halting is handled by the FSM, no datapath action
            OPC_STO: ctl.wr_ram = 1'b1;
            OPC_LD: begin
                ctl.rd_ram = 1'b1;
                ctl.sel_a  = SEL_A_RAM;
                ctl.wr_acc = 1'b1;
            end
            OPC_LDI: begin
                ctl.sel_a  = SEL_A_IMM;
                ctl.wr_acc = 1'b1;
            end
            OPC_ADD: begin
                ctl.rd_ram = 1'b1;
                ctl.sel_a  = SEL_A_ALU;
                ctl.sel_b  = 1'b0;
                ctl.op     = OP_ADD;
                ctl.wr_acc = 1'b1;
            end
            OPC_ADDI: begin
                ctl.sel_a  = SEL_A_ALU;
                ctl.sel_b  = 1'b1;
                ctl.op     = OP_ADD;
                ctl.wr_acc = 1'b1;
            end
            OPC_SUB: begin
                ctl.rd_ram = 1'b1;
                ctl.sel_a  = SEL_A_ALU;
                ctl.sel_b  = 1'b0;
                ctl.op     = OP_SUB;
                ctl.wr_acc = 1'b1;
            end
            OPC_SUBI: begin
                ctl.sel_a  = SEL_A_ALU;
                ctl.sel_b  = 1'b1;
                ctl.op     = OP_SUB;
                ctl.wr_acc = 1'b1;
            end
            // Undefined opcodes behave as NOPs that only raise illegal.
            default: ctl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// bip_control: multi-cycle control unit of the BIP accumulator processor.
// Every instruction takes FETCH -> DECODE -> EXEC; HLT parks the core in HALT.
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    bip_control_if.master: start / ROM data in; ROM address, operand,
//          RAM strobes, accumulator/ALU selects, halted, illegal, cycle count out
// Optional: define BIP_CYCLE_COUNT_EN to build the saturating run-cycle counter;
// otherwise o_cycle_count is tied to zero.
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    bip_control_if.master bus
);

    localparam int IW = OPCODE_WIDTH + PC_WIDTH;

    state_t                  state;
    logic [PC_WIDTH-1:0]     pc;
    logic [IW-1:0]           ir;
    logic                    halted_q;
    logic [OPCODE_WIDTH-1:0] rom_opcode;
    logic [OPCODE_WIDTH-1:0] dec_opcode;
    logic                    in_decode;
    logic                    in_exec;
    logic                    run;
    ctl_t                    dec;

    assign in_decode  = (state == ST_DECODE);
    assign in_exec    = (state == ST_EXEC);
    assign rom_opcode = bus.i_instr_data[IW-1:PC_WIDTH];

    // The RAM read has to be issued in DECODE, before IR holds the
    // instruction, so the decoder looks at the ROM output in that state.
    assign dec_opcode = in_decode ? rom_opcode : ir[IW-1:PC_WIDTH];

    bip_instr_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_dec (
        .opcode (dec_opcode),
        .ctl    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:   if (bus.i_start) state <= ST_FETCH;
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    ir <= bus.i_instr_data;
                    if (rom_opcode == OPC_HLT) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    pc    <= pc + 1'b1;  // wraps modulo 2^PC_WIDTH
                    state <= ST_FETCH;
                end
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Reset is synchronous, so the FSM still sits in EXEC during the reset
    // cycle; gating with reset keeps an aborted instruction from strobing.
    assign run = ~reset;

    assign bus.o_instr_addr = pc;
    assign bus.o_operand    = in_decode ? bus.i_instr_data[PC_WIDTH-1:0] : ir[PC_WIDTH-1:0];
    assign bus.o_rd_ram     = run & in_decode & dec.rd_ram;
    assign bus.o_wr_ram     = run & in_exec & dec.wr_ram;
    assign bus.o_wr_acc     = run & in_exec & dec.wr_acc;
    assign bus.o_illegal    = run & in_exec & dec.illegal;
    assign bus.o_sel_a      = (run & in_exec) ? dec.sel_a : 2'b00;
    assign bus.o_sel_b      = run & in_exec & dec.sel_b;
    assign bus.o_op         = run & in_exec & dec.op;
    assign bus.o_halted     = run & halted_q;

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;
    logic        cyc_tick;

    // The IDLE cycle that accepts start counts as the first run cycle.
    assign cyc_tick = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC) ||
                      ((state == ST_IDLE) && bus.i_start);

    always_ff @(posedge clk) begin
        if (reset)
            cyc_cnt <= '0;
        else if (cyc_tick && (cyc_cnt != 32'hFFFF_FFFF))
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    assign bus.o_cycle_count = cyc_cnt;
`else
    assign bus.o_cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rom [0:2047];
    logic [15:0] rom_q;
    int          checks = 0;
    int          errors = 0;

    bip_control_if #(.PC_WIDTH(11), .OPCODE_WIDTH(5)) bus ();

    bip_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // synchronous program ROM: data one cycle after address
    always @(posedge clk) rom_q <= rom[bus.o_instr_addr];
    assign bus.i_instr_data = rom_q;

    typedef struct {
        logic        newprog;
        int          prog;
        logic        start;
        logic [10:0] addr;
        logic [10:0] opnd;
        logic        rd, wr;
        logic [1:0]  sa;
        logic        sb, op, wa, h, il;
        int          cnt;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic np, input int p, input logic st, input int a,
                                input int o, input logic rd, input logic wr, input int sa,
                                input logic sb, input logic op, input logic wa, input logic h,
                                input logic il, input int c);
        row_t r;
        r.newprog = np; r.prog = p; r.start = st;
        r.addr = 11'(a); r.opnd = 11'(o); r.rd = rd; r.wr = wr; r.sa = 2'(sa);
        r.sb = sb; r.op = op; r.wa = wa; r.h = h; r.il = il; r.cnt = c;
        return r;
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef BIP_CYCLE_COUNT_EN
        return 32'(v);
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    function automatic logic [15:0] ins(input logic [4:0] o, input int a);
        return {o, 11'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        case (p)
            1: begin
                rom[0] = ins(5'b00011, 5);   // LDI 5
                rom[1] = ins(5'b00101, 3);   // ADDI 3
                rom[2] = ins(5'b00001, 7);   // STO 7
                rom[3] = ins(5'b00000, 0);   // HLT
            end
            2: begin
                rom[0] = ins(5'b00010, 4);   // LD 4
                rom[1] = ins(5'b00110, 2);   // SUB 2
                rom[2] = ins(5'b00000, 0);   // HLT
            end
            3: begin
                rom[0] = ins(5'b11111, 9);   // undefined
                rom[1] = ins(5'b00000, 0);   // HLT
            end
            default: begin
                for (int i = 0; i < 2048; i++) rom[i] = ins(5'b01000, 0);
            end
        endcase
    endtask

    // leaves the bench on a negedge with reset low and the FSM in IDLE
    task automatic do_reset();
        reset = 1'b1;
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [8:0] strobes();
        return {bus.o_rd_ram, bus.o_wr_ram, bus.o_sel_a, bus.o_sel_b, bus.o_op,
                bus.o_wr_acc, bus.o_illegal, bus.o_halted};
    endfunction

    task automatic wait_halt(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.o_halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic        ok;
        logic [10:0] last;
        logic        saw_wrap;
        int          seq_bad, ill_n;

        reset = 1'b1;
        bus.i_start = 1'b0;
        load_prog(1);
        @(negedge clk);
        do_reset();

        // reset state
        chk("rst_addr", 64'(bus.o_instr_addr), 64'd0);
        chk("rst_strobes", 64'(strobes()), 64'd0);
        chk("rst_cnt", 64'(bus.o_cycle_count), 64'd0);

        // program 1: LDI 5; ADDI 3; STO 7; HLT (idle row first, start ignored later)
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 1, 0, 1, 3, 0, 0, 2, 1, 0, 1, 0, 0, 6));
        tbl.push_back(mk(0, 1, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 1, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(0, 1, 0, 2, 7, 0, 1, 0, 0, 0, 0, 0, 0, 9));
        tbl.push_back(mk(0, 1, 0, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12));
        // program 2: LD 4; SUB 2; HLT
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 2, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 2, 0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 2, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 2, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 2, 0, 1, 2, 0, 0, 2, 0, 1, 1, 0, 0, 6));
        tbl.push_back(mk(0, 2, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(0, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9));
        tbl.push_back(mk(0, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9));
        // program 3: undefined opcode at addr 0, then HLT
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 3, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 3, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(0, 3, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6));
        tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6));

        foreach (tbl[i]) begin
            if (tbl[i].newprog) begin
                load_prog(tbl[i].prog);
                do_reset();
            end
            bus.i_start = tbl[i].start;
            chk($sformatf("row%0d_p%0d_out", i, tbl[i].prog),
                64'({bus.o_instr_addr, bus.o_operand, bus.o_rd_ram, bus.o_wr_ram, bus.o_sel_a,
                     bus.o_sel_b, bus.o_op, bus.o_wr_acc, bus.o_halted, bus.o_illegal}),
                64'({tbl[i].addr, tbl[i].opnd, tbl[i].rd, tbl[i].wr, tbl[i].sa,
                     tbl[i].sb, tbl[i].op, tbl[i].wa, tbl[i].h, tbl[i].il}));
            chk($sformatf("row%0d_p%0d_cnt", i, tbl[i].prog),
                64'(bus.o_cycle_count), 64'(cnt_exp(tbl[i].cnt)));
            @(negedge clk);
        end
        bus.i_start = 1'b0;

        // reset asserted during EXEC of STO
        load_prog(1);
        do_reset();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (7) @(negedge clk);             // cycle 8: DECODE of STO
        @(posedge clk);
        #1 reset = 1'b1;                       // cycle 9: EXEC of STO
        @(negedge clk);
        chk("rstexec_wr_ram", 64'(bus.o_wr_ram), 64'd0);
        chk("rstexec_strobes", 64'(strobes()), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstexec_after_strobes", 64'(strobes()), 64'd0);
        chk("rstexec_after_addr", 64'(bus.o_instr_addr), 64'd0);
        chk("rstexec_after_cnt", 64'(bus.o_cycle_count), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rstexec_idle%0d", k),
                64'({bus.o_instr_addr, bus.o_operand, strobes()}), 64'd0);
        end
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_halt(40, ok);
        chk("rstexec_rerun_halt", 64'(ok), 64'd1);
        chk("rstexec_rerun_addr", 64'(bus.o_instr_addr), 64'd3);

        // PC wrap: all NOPs, addr 0 becomes HLT once its first fetch is done
        load_prog(0);
        do_reset();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        rom[0] = ins(5'b00000, 0);
        last = 11'd0;
        saw_wrap = 1'b0;
        seq_bad = 0;
        ill_n = 0;
        ok = 1'b0;
        for (int k = 0; k < 7000; k++) begin
            if (bus.o_illegal) ill_n++;
            if (bus.o_instr_addr != last) begin
                if (bus.o_instr_addr != last + 11'd1) seq_bad++;
                if (last == 11'd2047 && bus.o_instr_addr == 11'd0) saw_wrap = 1'b1;
                last = bus.o_instr_addr;
            end
            if (bus.o_halted) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wrap_halted", 64'(ok), 64'd1);
        chk("wrap_seen", 64'(saw_wrap), 64'd1);
        chk("wrap_seq", 64'(seq_bad), 64'd0);
        chk("wrap_halt_addr", 64'(bus.o_instr_addr), 64'd0);
        chk("wrap_illegal_n", 64'(ill_n), 64'd2048);
        chk("wrap_cnt", 64'(bus.o_cycle_count), 64'(cnt_exp(6147)));
        @(negedge clk);
        chk("wrap_cnt_hold", 64'(bus.o_cycle_count), 64'(cnt_exp(6147)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
